chop_gen_mc: RTL and testbench
==============================

// Module: chop_gen_mc
// PURPOSE
// - Multi-channel successor of the single-channel chopper generator: one shared period counter drives N_CH chop outputs.
// - Each channel has its own idle level and its own inversion bit.
// - Adds a run-time selectable output delay, a programmable ADC-hold window and period-boundary shadowing of the configuration.
// - Sits between the control registers and the ADC/chopper front-end of the interlock acquisition path.
// PARAMETERS
// - N_CH    16  number of chop channels
// - CNT_W   32  width of the period counter and the count inputs
// - HOLD_W   8  width of hold_samples
// - DLY_MAX  8  depth of the delay line (max delay, in clk cycles)
// - DSEL_W   4  width of dly_sel; must satisfy 2**DSEL_W > DLY_MAX
// PORTS
// - clk            in   1       single clock; all logic on posedge
// - reset          in   1       synchronous, active-high
// - chop_en        in   1       synchronous enable; low = idle and reload config
// - chop_default   in   N_CH    per-channel level during the first phase
// - phase_inv      in   N_CH    per-channel XOR applied to chop_default
// - change_count   in   CNT_W   cycles spent in the first phase
// - max_count      in   CNT_W   period length in cycles
// - hold_samples   in   HOLD_W  hold-window length after each edge; 0 = no hold
// - dly_sel        in   DSEL_W  output delay 0..DLY_MAX; larger values clamp to DLY_MAX
// - chop_o         out  N_CH    undelayed chop outputs
// - chop_dly_o     out  N_CH    chop_o delayed by dly_sel cycles
// - data_hold_o    out  1       hold window, delayed by dly_sel cycles
// - period_strb_o  out  1       1-cycle pulse on the first cycle of each period
// - cfg_err_o      out  1       shadowed configuration is invalid
// BEHAVIOUR
// - Reset values:
//   - cnt = 0, chop_o = 0, hold_cnt = 0, delay lines = 0.
//   - chop_dly_o = 0, data_hold_o = 0, period_strb_o = 0, cfg_err_o = 0.
// - Definitions: lvl = chop_default ^ phase_inv, evaluated from shadow registers.
// - Shadow registers: sh_chg, sh_max, sh_hold, sh_lvl.
//   - Load every cycle while chop_en = 0.
//   - Load on the wrap cycle (cnt == sh_max-1).
//   - A mid-period config change takes effect at the next period only.
//   - dly_sel is not shadowed; it applies immediately.
// - Validity: invalid when sh_max < 2, sh_chg == 0, or sh_chg >= sh_max.
//   - While invalid: cfg_err_o = 1, cnt held at 0, chop_o = sh_lvl, hold off, no strobe.
//   - The shadows keep reloading every cycle until the config is valid.
// - chop_en = 0: cnt <= 0, chop_o <= lvl, hold_cnt <= 0, period_strb_o <= 0.
// - First enabled cycle (chop_en rising, config valid):
//   - cnt counts from 0; chop_o = sh_lvl.
//   - period_strb_o = 1 for one cycle.
//   - hold_cnt loaded with sh_hold.
// - Running: cnt increments by 1 per clk.
//   - cnt == sh_chg-1: next cycle chop_o = ~sh_lvl; hold_cnt <= sh_hold.
//   - cnt == sh_max-1: next cycle cnt = 0, chop_o = sh_lvl, period_strb_o = 1, hold_cnt <= new sh_hold.
//   - Result per period: sh_chg cycles at lvl, then (sh_max - sh_chg) cycles at ~lvl.
// - Hold window: hold_r = (hold_cnt != 0); hold_cnt decrements to 0 and saturates there.
//   - An edge arriving while hold_cnt != 0 reloads the counter, so overlapping windows merge with no gap.
// - Delay line (chop_o and hold_r together):
//   - Tap = min(dly_sel, DLY_MAX); tap 0 passes through combinationally from the registered chop_o / hold_r.
//   - The line keeps shifting when chop_en = 0 and is cleared only by reset.
// - Arithmetic: cnt is CNT_W bits and unsigned; comparisons use no overflow (validity guarantees sh_chg-1 >= 0).
// - Simultaneous events: reset beats chop_en; chop_en = 0 beats wrap/change. Reset mid-period restarts from the reset values.
// STRUCTURE
// - Package chop_pkg: CNT_W, HOLD_W and DLY_MAX defaults; the cfg_valid() function.
// - Sub-module chop_dly_line: parametrised width W and depth DLY_MAX, variable tap, sync reset.
//   - Instantiated once with W = N_CH+1.
// - Top level: shadow registers, counter/phase logic, hold counter.
// TESTING
// 1. chg=3, max=8, hold=2, dly=0, default=0x0001, inv=0:
//    - ch0 reads 1,1,1,0,0,0,0,0 repeating.
//    - Other channels read the complement.
//    - Hold is high on cycles 0-1 and 3-4.
//    - Strobe every 8 cycles.
// 2. Same config with dly=3:
//    - chop_dly_o equals chop_o shifted exactly 3 cycles.
//    - data_hold_o is aligned with chop_dly_o.
//    - dly=15 gives a delay of 8 cycles.
// 3. Change max 8->12 at cnt=5:
//    - The current period ends at 8 cycles.
//    - The next period is 12 cycles; the change is applied at the wrap.
// 4. Invalid configs chg=0 / chg=max / max=1:
//    - cfg_err_o = 1, chop_o stays at lvl, no strobe.
//    - Writing chg=2, max=4 recovers on the next cycle.
// 5. hold=5 with chg=2, max=4:
//    - data_hold_o stays continuously high while enabled.
//    - hold=0 never asserts hold.
// 6. Reset and chop_en low mid-period:
//    - reset forces all outputs to 0 on the next cycle.
//    - chop_en low forces cnt=0 and chop_o=lvl; re-enable restarts the period with a strobe.

Source files
------------

// File: rtl/chop_pkg.sv
// rtl/chop_pkg.sv - shared defaults and configuration check for the chopper generator
package chop_pkg;

  localparam int CNT_W   = 32;
  localparam int HOLD_W  = 8;
  localparam int DLY_MAX = 8;

  // A period needs at least two cycles and both phases must be non-empty.
  function automatic logic cfg_valid(input logic [CNT_W-1:0] chg,
                                     input logic [CNT_W-1:0] mx);
    return (mx >= CNT_W'(2)) && (chg != '0) && (chg < mx);
  endfunction

endpackage

// File: rtl/chop_dly_line.sv
// rtl/chop_dly_line.sv - fixed-depth shift line with a run-time selectable tap
module chop_dly_line #(
  parameter int W       = 17,
  parameter int DLY_MAX = 8,
  parameter int TAP_W   = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [W-1:0]     src,
  input  logic [TAP_W-1:0] tap,
  output logic [W-1:0]     tapped
);

  logic [W-1:0]     line [DLY_MAX];
  logic [TAP_W-1:0] tap_c;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < DLY_MAX; k++) line[k] <= '0;
    end else begin
      line[0] <= src;
      for (int k = 1; k < DLY_MAX; k++) line[k] <= line[k-1];
    end
  end

  // Tap 0 is a straight pass-through; taps beyond the line depth clamp to the last stage.
  always_comb begin
    tap_c  = (tap > TAP_W'(DLY_MAX)) ? TAP_W'(DLY_MAX) : tap;
    tapped = src;
    for (int k = 0; k < DLY_MAX; k++) begin
      if (tap_c == TAP_W'(k + 1)) tapped = line[k];
    end
  end

endmodule

// File: rtl/chop_gen_mc.sv
// rtl/chop_gen_mc.sv - multi-channel chopper generator with shadowed config, hold window and output delay
module chop_gen_mc #(
  parameter int N_CH    = 16,
  parameter int CNT_W   = chop_pkg::CNT_W,
  parameter int HOLD_W  = chop_pkg::HOLD_W,
  parameter int DLY_MAX = chop_pkg::DLY_MAX,
  parameter int DSEL_W  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              chop_en,
  input  logic [N_CH-1:0]   chop_default,
  input  logic [N_CH-1:0]   phase_inv,
  input  logic [CNT_W-1:0]  change_count,
  input  logic [CNT_W-1:0]  max_count,
  input  logic [HOLD_W-1:0] hold_samples,
  input  logic [DSEL_W-1:0] dly_sel,
  output logic [N_CH-1:0]   chop_o,
  output logic [N_CH-1:0]   chop_dly_o,
  output logic              data_hold_o,
  output logic              period_strb_o,
  output logic              cfg_err_o
);
  import chop_pkg::*;

  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  sh_chg;
  logic [CNT_W-1:0]  sh_max;
  logic [HOLD_W-1:0] sh_hold;
  logic [N_CH-1:0]   sh_lvl;
  logic [HOLD_W-1:0] hold_cnt;
  logic [N_CH-1:0]   in_lvl;
  logic              run;
  logic              valid;
  logic              wrap;
  logic              change;
  logic              sh_load;
  logic              hold_r;

  assign in_lvl  = chop_default ^ phase_inv;
  assign valid   = cfg_valid(sh_chg, sh_max);
  assign wrap    = run && (cnt == sh_max - CNT_W'(1));
  assign change  = run && (cnt == sh_chg - CNT_W'(1));
  assign sh_load = !chop_en || !valid || wrap;
  assign hold_r  = (hold_cnt != '0);

  // Config only moves into the shadows at period boundaries, while idle, or while unusable.
  always_ff @(posedge clk) begin
    if (reset) begin
      sh_chg  <= '0;
      sh_max  <= '0;
      sh_hold <= '0;
      sh_lvl  <= '0;
    end else if (sh_load) begin
      sh_chg  <= change_count;
      sh_max  <= max_count;
      sh_hold <= hold_samples;
      sh_lvl  <= in_lvl;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt           <= '0;
      chop_o        <= '0;
      hold_cnt      <= '0;
      period_strb_o <= 1'b0;
      cfg_err_o     <= 1'b0;
      run           <= 1'b0;
    end else begin
      cfg_err_o <= !valid;
      if (!chop_en || !valid) begin
        cnt           <= '0;
        chop_o        <= sh_lvl;
        hold_cnt      <= '0;
        period_strb_o <= 1'b0;
        run           <= 1'b0;
      end else if (!run) begin
        run           <= 1'b1;
        cnt           <= '0;
        chop_o        <= sh_lvl;
        hold_cnt      <= sh_hold;
        period_strb_o <= 1'b1;
      end else if (wrap) begin
        // The shadows reload on this same edge, so the new period takes the incoming config.
        cnt           <= '0;
        chop_o        <= in_lvl;
        hold_cnt      <= hold_samples;
        period_strb_o <= 1'b1;
      end else begin
        cnt           <= cnt + CNT_W'(1);
        period_strb_o <= 1'b0;
        if (change) begin
          chop_o   <= ~sh_lvl;
          hold_cnt <= sh_hold;
        end else if (hold_r) begin
          hold_cnt <= hold_cnt - HOLD_W'(1);
        end
      end
    end
  end

  chop_dly_line #(
    .W       (N_CH + 1),
    .DLY_MAX (DLY_MAX),
    .TAP_W   (DSEL_W)
  ) u_dly (
    .clk    (clk),
    .reset  (reset),
    .src    ({hold_r, chop_o}),
    .tap    (dly_sel),
    .tapped ({data_hold_o, chop_dly_o})
  );

endmodule

// File: tb/tb_chop_gen_mc.sv
// tb/tb_chop_gen_mc.sv - directed self-checking bench for chop_gen_mc
module tb_chop_gen_mc;

  logic        clk = 1'b0;
  logic        reset;
  logic        chop_en;
  logic [15:0] chop_default;
  logic [15:0] phase_inv;
  logic [31:0] change_count;
  logic [31:0] max_count;
  logic [7:0]  hold_samples;
  logic [3:0]  dly_sel;
  logic [15:0] chop_o;
  logic [15:0] chop_dly_o;
  logic        data_hold_o;
  logic        period_strb_o;
  logic        cfg_err_o;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  chop_gen_mc dut (
    .clk           (clk),
    .reset         (reset),
    .chop_en       (chop_en),
    .chop_default  (chop_default),
    .phase_inv     (phase_inv),
    .change_count  (change_count),
    .max_count     (max_count),
    .hold_samples  (hold_samples),
    .dly_sel       (dly_sel),
    .chop_o        (chop_o),
    .chop_dly_o    (chop_dly_o),
    .data_hold_o   (data_hold_o),
    .period_strb_o (period_strb_o),
    .cfg_err_o     (cfg_err_o)
  );

  // Expected chop_o for chg=3, max=8, lvl=0x0001; negative cycles are idle time at lvl.
  function automatic logic [15:0] pat(input int i);
    if (i < 0) return 16'h0001;
    return ((i % 8) < 3) ? 16'h0001 : 16'hFFFE;
  endfunction

  function automatic logic hp(input int i);
    int m;
    if (i < 0) return 1'b0;
    m = i % 8;
    return (m == 0) || (m == 1) || (m == 3) || (m == 4);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic setup(input int chg, input int mx, input int hold, input int dly);
    chop_en      = 1'b0;
    change_count = chg;
    max_count    = mx;
    hold_samples = hold[7:0];
    dly_sel      = dly[3:0];
    chop_default = 16'h0001;
    phase_inv    = 16'h0000;
    repeat (4) step();
  endtask

  task automatic test_reset();
    reset        = 1'b1;
    chop_en      = 1'b1;
    chop_default = 16'hFFFF;
    phase_inv    = 16'h0000;
    change_count = 3;
    max_count    = 8;
    hold_samples = 2;
    dly_sel      = 0;
    repeat (2) step();
    total++; if (chop_o !== 16'h0) begin bad++; $display("FAIL reset_chop got=%h exp=0000", chop_o); end
    total++; if (chop_dly_o !== 16'h0) begin bad++; $display("FAIL reset_dly got=%h exp=0000", chop_dly_o); end
    total++; if (data_hold_o !== 1'b0) begin bad++; $display("FAIL reset_hold got=%b exp=0", data_hold_o); end
    total++; if (period_strb_o !== 1'b0) begin bad++; $display("FAIL reset_strb got=%b exp=0", period_strb_o); end
    total++; if (cfg_err_o !== 1'b0) begin bad++; $display("FAIL reset_err got=%b exp=0", cfg_err_o); end
    reset = 1'b0;
  endtask

  task automatic test_basic();
    setup(3, 8, 2, 0);
    total++; if (chop_o !== 16'h0001) begin bad++; $display("FAIL idle_lvl got=%h exp=0001", chop_o); end
    chop_en = 1'b1;
    for (int i = 0; i < 16; i++) begin
      step();
      total++; if (chop_o !== pat(i)) begin bad++; $display("FAIL basic_chop c=%0d got=%h exp=%h", i, chop_o, pat(i)); end
      total++; if (chop_dly_o !== pat(i)) begin bad++; $display("FAIL basic_dly0 c=%0d got=%h exp=%h", i, chop_dly_o, pat(i)); end
      total++; if (data_hold_o !== hp(i)) begin bad++; $display("FAIL basic_hold c=%0d got=%b exp=%b", i, data_hold_o, hp(i)); end
      total++; if (period_strb_o !== ((i % 8) == 0)) begin bad++; $display("FAIL basic_strb c=%0d got=%b exp=%b", i, period_strb_o, (i % 8) == 0); end
      total++; if (cfg_err_o !== 1'b0) begin bad++; $display("FAIL basic_err c=%0d got=%b exp=0", i, cfg_err_o); end
    end
  endtask

  task automatic test_delay();
    setup(3, 8, 2, 3);
    chop_en = 1'b1;
    for (int i = 0; i < 40; i++) begin
      int d;
      if (i == 24) dly_sel = 4'd15;
      d = (i < 24) ? 3 : 8;
      step();
      total++; if (chop_o !== pat(i)) begin bad++; $display("FAIL dly_chop c=%0d got=%h exp=%h", i, chop_o, pat(i)); end
      total++; if (chop_dly_o !== pat(i - d)) begin bad++; $display("FAIL dly_out c=%0d d=%0d got=%h exp=%h", i, d, chop_dly_o, pat(i - d)); end
      total++; if (data_hold_o !== hp(i - d)) begin bad++; $display("FAIL dly_hold c=%0d d=%0d got=%b exp=%b", i, d, data_hold_o, hp(i - d)); end
    end
  endtask

  task automatic test_shadow();
    setup(3, 8, 2, 0);
    chop_en = 1'b1;
    for (int i = 0; i < 34; i++) begin
      int p;
      logic es;
      step();
      p  = (i < 8) ? i : (i - 8) % 12;
      es = (i == 0) || (i == 8) || (i == 20) || (i == 32);
      total++; if (period_strb_o !== es) begin bad++; $display("FAIL shadow_strb c=%0d got=%b exp=%b", i, period_strb_o, es); end
      total++; if (chop_o !== ((p < 3) ? 16'h0001 : 16'hFFFE)) begin bad++; $display("FAIL shadow_chop c=%0d got=%h p=%0d", i, chop_o, p); end
      if (i == 5) max_count = 12;
    end
  endtask

  task automatic test_invalid();
    int chg_t [3] = '{0, 8, 3};
    int max_t [3] = '{8, 8, 1};
    for (int t = 0; t < 3; t++) begin
      setup(chg_t[t], max_t[t], 2, 0);
      chop_en = 1'b1;
      for (int i = 0; i < 4; i++) begin
        step();
        total++; if (cfg_err_o !== 1'b1) begin bad++; $display("FAIL inv_err t=%0d got=%b exp=1", t, cfg_err_o); end
        total++; if (chop_o !== 16'h0001) begin bad++; $display("FAIL inv_chop t=%0d got=%h exp=0001", t, chop_o); end
        total++; if (period_strb_o !== 1'b0) begin bad++; $display("FAIL inv_strb t=%0d got=%b exp=0", t, period_strb_o); end
        total++; if (data_hold_o !== 1'b0) begin bad++; $display("FAIL inv_hold t=%0d got=%b exp=0", t, data_hold_o); end
      end
      change_count = 2;
      max_count    = 4;
      repeat (2) step();
      total++; if (period_strb_o !== 1'b1) begin bad++; $display("FAIL rec_strb t=%0d got=%b exp=1", t, period_strb_o); end
      total++; if (cfg_err_o !== 1'b0) begin bad++; $display("FAIL rec_err t=%0d got=%b exp=0", t, cfg_err_o); end
      repeat (2) step();
      total++; if (chop_o !== 16'hFFFE) begin bad++; $display("FAIL rec_chop t=%0d got=%h exp=fffe", t, chop_o); end
    end
  endtask

  task automatic test_hold();
    setup(2, 4, 5, 0);
    chop_en = 1'b1;
    for (int i = 0; i < 12; i++) begin
      step();
      total++; if (data_hold_o !== 1'b1) begin bad++; $display("FAIL hold5 c=%0d got=%b exp=1", i, data_hold_o); end
      total++; if (chop_o !== (((i % 4) < 2) ? 16'h0001 : 16'hFFFE)) begin bad++; $display("FAIL hold5_chop c=%0d got=%h", i, chop_o); end
    end
    setup(2, 4, 0, 0);
    chop_en = 1'b1;
    for (int i = 0; i < 12; i++) begin
      step();
      total++; if (data_hold_o !== 1'b0) begin bad++; $display("FAIL hold0 c=%0d got=%b exp=0", i, data_hold_o); end
    end
  endtask

  task automatic test_midperiod();
    setup(3, 8, 2, 3);
    chop_en = 1'b1;
    repeat (5) step();
    reset = 1'b1;
    step();
    total++; if (chop_o !== 16'h0) begin bad++; $display("FAIL mid_rst_chop got=%h exp=0000", chop_o); end
    total++; if (chop_dly_o !== 16'h0) begin bad++; $display("FAIL mid_rst_dly got=%h exp=0000", chop_dly_o); end
    total++; if (data_hold_o !== 1'b0) begin bad++; $display("FAIL mid_rst_hold got=%b exp=0", data_hold_o); end
    total++; if (period_strb_o !== 1'b0) begin bad++; $display("FAIL mid_rst_strb got=%b exp=0", period_strb_o); end
    reset = 1'b0;
    setup(3, 8, 2, 0);
    chop_en = 1'b1;
    repeat (6) step();
    total++; if (chop_o !== 16'hFFFE) begin bad++; $display("FAIL mid_pre_chop got=%h exp=fffe", chop_o); end
    chop_en = 1'b0;
    step();
    total++; if (chop_o !== 16'h0001) begin bad++; $display("FAIL mid_off_chop got=%h exp=0001", chop_o); end
    total++; if (period_strb_o !== 1'b0) begin bad++; $display("FAIL mid_off_strb got=%b exp=0", period_strb_o); end
    chop_en = 1'b1;
    for (int i = 0; i < 9; i++) begin
      step();
      total++; if (period_strb_o !== ((i % 8) == 0)) begin bad++; $display("FAIL mid_re_strb c=%0d got=%b", i, period_strb_o); end
      total++; if (chop_o !== pat(i)) begin bad++; $display("FAIL mid_re_chop c=%0d got=%h exp=%h", i, chop_o, pat(i)); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_delay();
    test_shadow();
    test_invalid();
    test_hold();
    test_midperiod();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
